// File: rtl/rot4_pkg.sv
// Shared types and constants for the two-requester 4-bit rotate arbiter.
package rot4_pkg;
  localparam int ROT_W = 4;

  typedef enum logic {ROT_LEFT = 1'b0, ROT_RIGHT = 1'b1} rot_dir_e;

  typedef struct packed {
    logic [ROT_W-1:0] data;
    logic [1:0]       amt;
    rot_dir_e         dir;
  } rot_req_t;

  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_e;

  // A left rotate by k is the right rotate by (4-k) mod 4.
  function automatic logic [1:0] right_amt(input rot_dir_e dir, input logic [1:0] amt);
    return (dir == ROT_RIGHT) ? amt : (2'd0 - amt);
  endfunction
endpackage

// File: rtl/rot4_arbiter_if.sv
// Request/response bundle between the two clients, the consumer and the arbiter.
interface rot4_arbiter_if;
  import rot4_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [ROT_W-1:0] req0_data;
  logic [1:0]       req0_amt;
  logic             req0_dir;
  logic             req1_valid;
  logic             req1_ready;
  logic [ROT_W-1:0] req1_data;
  logic [1:0]       req1_amt;
  logic             req1_dir;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ROT_W-1:0] rsp_data;
  logic             rsp_id;

  modport master (
    output req0_valid, req0_data, req0_amt, req0_dir,
    output req1_valid, req1_data, req1_amt, req1_dir,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_dir,
    input  req1_valid, req1_data, req1_amt, req1_dir,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/barrel_shifter.sv
// Combinational 4-bit rotator; every rotate is normalised to a right rotate.
module barrel_shifter
  import rot4_pkg::*;
(
  input  logic [ROT_W-1:0] data_i,
  input  logic [1:0]       amt_i,
  input  rot_dir_e         dir_i,
  output logic [ROT_W-1:0] data_o
);
  logic [1:0] rsh;

  always_comb begin
    rsh = right_amt(dir_i, amt_i);
    unique case (rsh)
      2'd0:    data_o = data_i;
      2'd1:    data_o = {data_i[0],   data_i[3:1]};
      2'd2:    data_o = {data_i[1:0], data_i[3:2]};
      default: data_o = {data_i[2:0], data_i[3]};
    endcase
  end
endmodule

// File: rtl/rot4_arbiter.sv
// Round-robin arbiter sharing one rotator between two requesters, with a
// one-entry registered output stage tagged by the winning requester.
module rot4_arbiter
  import rot4_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rot4_arbiter_if.slave  bus
);
  out_state_e       state_q, state_d;
  logic [ROT_W-1:0] data_q, data_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             can_accept;
  logic             grant;
  logic             ready0, ready1, accept;
  rot_req_t         sel;
  logic [ROT_W-1:0] rot;

  assign can_accept = (state_q == OUT_EMPTY) || bus.rsp_ready;

  // Contested cycles go to whoever did not win last time.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_q;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  assign ready0 = !rst && can_accept && bus.req0_valid && !grant;
  assign ready1 = !rst && can_accept && bus.req1_valid &&  grant;
  assign accept = ready0 || ready1;

  always_comb begin
    if (grant) sel = '{data: bus.req1_data, amt: bus.req1_amt, dir: rot_dir_e'(bus.req1_dir)};
    else       sel = '{data: bus.req0_data, amt: bus.req0_amt, dir: rot_dir_e'(bus.req0_dir)};
  end

  barrel_shifter u_rot (
    .data_i (sel.data),
    .amt_i  (sel.amt),
    .dir_i  (sel.dir),
    .data_o (rot)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;
    if (accept) begin
      state_d = OUT_FULL;
      data_d  = rot;
      id_d    = grant;
      last_d  = grant;
    end else if (state_q == OUT_FULL && bus.rsp_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = (state_q == OUT_FULL);
  assign bus.rsp_data   = data_q;
  assign bus.rsp_id     = id_q;
endmodule

// File: doc/rot4_arbiter.md
# rot4_arbiter

Two-requester round-robin arbiter and sequencer for the shared 4-bit combinational rotator (barrel_shifter). It accepts rotate requests (data, amount, direction) from two clients over valid/ready handshakes, grants one per cycle, drives the rotator, and registers the result into a one-entry output stage tagged with the winning requester's ID. It sits between the two datapath clients and the single rotator instance, so they share it without contention.

## Interface
- No parameters. Data width is fixed at 4 and requester count at 2.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a request.
- `req0_ready` out 1: requester 0's request is accepted this cycle.
- `req0_data` in 4: value to rotate.
- `req0_amt` in 2: rotate amount, 0–3.
- `req0_dir` in 1: direction, 0 = left, 1 = right.
- `req1_valid` / `req1_ready` / `req1_data` / `req1_amt` / `req1_dir`: same as requester 0, for requester 1.
- `rsp_valid` out 1: the output register holds a result.
- `rsp_ready` in 1: the consumer accepts the result.
- `rsp_data` out 4: rotated value.
- `rsp_id` out 1: requester that produced `rsp_data`.

## Operation
- **Output stage states:** EMPTY and FULL.
  - EMPTY → FULL on accept.
  - FULL → EMPTY when `rsp_valid && rsp_ready` and no new accept in that cycle.
  - FULL → FULL when the output drains and a new request is accepted in the same cycle.
- **Capacity:** `can_accept = !rsp_valid || rsp_ready`.
- **Grant:**
  - If only one `reqN_valid` is high, it wins.
  - If both are high, the requester not equal to `last_grant` wins.
  - With no valid request, there is no grant and `last_grant` is unchanged.
- **Ready:**
  - `reqN_ready = can_accept && grant==N && reqN_valid`.
  - Ready is combinational from `valid`, `rsp_valid` and `rsp_ready`.
  - At most one ready is high per cycle.
- **On accept:**
  - The granted request's data, amt and dir are muxed into the rotator.
  - Rotator output → `rsp_data`, granted index → `rsp_id`.
  - `rsp_valid` ← 1 and `last_grant` ← granted index.
- **Rotation semantics:** left rotate by k equals right rotate by (4−k) mod 4, and amt 0 passes data through in either direction. Examples:
  - 4'b1001 left 1 = 4'b0011.
  - 4'b1001 right 1 = 4'b1100.
  - 4'b1001 left 2 = 4'b0110.
- **Output hold:** while `rsp_valid && !rsp_ready`, `rsp_data` and `rsp_id` are held stable, and both `reqN_ready` are 0.
- **Requester side:** requesters must hold their fields stable while `valid && !ready`. A requester may drop `valid` before acceptance; the arbiter does not latch it.

## Timing
- **Reset values:** `rsp_valid`=0, `rsp_data`=4'b0000, `rsp_id`=0, `last_grant`=1 (so requester 0 wins the first contested cycle), state EMPTY.
- **Ready during reset:** both `reqN_ready` are 0 while `rst` is high, whatever `valid` is.
- **Latency:** a request accepted in cycle N shows `rsp_valid`=1 with its result in cycle N+1.
- **Throughput:** one result per cycle when `rsp_ready` is held high, alternating requesters under continuous contention.
- **Simultaneous drain and accept:** the new result replaces the old with no bubble.
- **Reset mid-operation:** a held result is discarded and `rsp_valid` is 0 the next cycle. A request presented in the reset cycle is not accepted.
- **Combinational paths:** none from `rsp_ready` to `rsp_data` or `rsp_id`. The only combinational paths are `rsp_ready`/`valid` → `reqN_ready`.

## Structure
- **Package `rot4_pkg`:**
  - `typedef rot_dir_e {ROT_LEFT=0, ROT_RIGHT=1}`.
  - `typedef struct {logic [3:0] data; logic [1:0] amt; rot_dir_e dir;} rot_req_t`.
  - `typedef enum {OUT_EMPTY, OUT_FULL}`.
  - Constant `ROT_W=4`.
- **Sub-module:** one instance of the existing combinational rotator barrel_shifter, fed by the grant mux. No other sub-modules. Grant logic, output register and state stay in this module.

## Test plan
- **Reset:** assert `rst` for 2 cycles with both valids high → both readies are 0, `rsp_valid`=0, `rsp_data`=0. Release → requester 0 is accepted first.
- **Single request:** req0 {1001, amt 1, left}, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_data`=0011, `rsp_id`=0. Repeat with right, amt 1 → 1100. Repeat with amt 0 in either direction → 1001.
- **Contention:** both valid for 4 cycles with `rsp_ready`=1, req0 {0001, amt 1, left} and req1 {1000, amt 2, right} → `rsp_id` sequence 0,1,0,1 and `rsp_data` 0010,0010,0010,0010.
- **Backpressure:** `rsp_ready`=0 for 3 cycles with result 0110 held → `rsp_data` stays 0110, both readies are 0. Raise `rsp_ready` with req1 valid → drain and accept in the same cycle, no bubble.
- **Exhaustive check:** all 16 data × 4 amt × 2 dir through req1 → each result matches the reference rotate model, and left k equals right (4−k) mod 4.
- **Reset mid-operation:** `rst` while FULL and req0 valid → `rsp_valid`=0 the next cycle and no acceptance in the reset cycle. After release, the first contested grant goes to req0.
